ddmtd_meas_ctrl: RTL and testbench

//  Sequences one DDMTD phase measurement around the ddmtd_sampler. Generates its helper_tick

---
 rtl/ddmtd_pkg.sv | 16 +
 rtl/ddmtd_helper_div.sv | 50 +++++
 rtl/ddmtd_meas_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ddmtd_meas_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddmtd_pkg.sv
// ddmtd_pkg
//   Types and defaults shared by the DDMTD measurement controller and the
//   ddmtd_sampler it drives.
//   Contents: COUNT_W_DEF (default phase counter width) and state_t, the
//   measurement sequencer state enum.
package ddmtd_pkg;

  localparam int COUNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    ACCUM   = 2'd2
  } state_t;

endpackage

// File: rtl/ddmtd_helper_div.sv
// ddmtd_helper_div
//   Programmable divider that produces the sampler helper tick from clk_sys.
//   While en is high it counts 0..div and pulses tick for one cycle each time
//   the count reaches div, which gives a period of div+1 cycles. The counter
//   clears whenever en is low, so every measurement starts from phase zero.
// Ports
//   clk_sys  in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   run enable
//   div      in   [DIV_W] terminal count (period - 1)
//   tick     out  registered 1-cycle pulse
module ddmtd_helper_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en) begin
      if (cnt_q == div) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/ddmtd_meas_ctrl.sv
// ddmtd_meas_ctrl
//   Sequences one DDMTD phase measurement around ddmtd_sampler: enables the
//   sampler, generates its helper tick, throws away the first (stale) phase
//   result, then averages 2^avg_log2 results and reports the average. If the
//   sampler stops delivering results for TMO_TICKS helper ticks, the
//   measurement is aborted with a timeout pulse.
// Ports
//   clk_sys         in   system clock
//   rst_n           in   asynchronous active-low reset
//   ena             in   global enable, low aborts a measurement
//   start           in   1-cycle measurement request
//   cfg_div         in   [DIV_W] helper tick period - 1
//   cfg_avg_log2    in   [3] log2 of samples averaged (clamped to AVG_MAX)
//   phase_valid     in   sampler result strobe
//   phase_err_beat  in   [COUNT_W] signed sampler result
//   helper_tick     out  helper tick pulse to the sampler
//   sampler_ena     out  sampler enable (same as busy)
//   busy            out  measurement in progress
//   done            out  1-cycle pulse, avg_phase updated
//   timeout         out  1-cycle pulse, measurement aborted
//   avg_phase       out  [COUNT_W] signed average, held until next done
module ddmtd_meas_ctrl
  import ddmtd_pkg::*;
#(
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int DIV_W     = 8,
  parameter int AVG_MAX   = 4,
  parameter int TMO_TICKS = 1024
) (
  input  logic                      clk_sys,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      start,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic [2:0]                cfg_avg_log2,
  input  logic                      phase_valid,
  input  logic signed [COUNT_W-1:0] phase_err_beat,
  output logic                      helper_tick,
  output logic                      sampler_ena,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic signed [COUNT_W-1:0] avg_phase
);

  localparam int ACC_W = COUNT_W + AVG_MAX;
  localparam int CNT_W = AVG_MAX + 1;
  localparam int TMO_W = $clog2(TMO_TICKS + 1);

  state_t                    state_q, state_d;
  logic [DIV_W-1:0]          div_l_q, div_l_d;
  logic [2:0]                avg_l_q, avg_l_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      timeout_q, timeout_d;
  logic signed [COUNT_W-1:0] avg_q, avg_d;

  logic signed [ACC_W-1:0]   beat_ext;
  logic signed [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]          cnt_next;
  logic [CNT_W-1:0]          cnt_target;
  logic [TMO_W-1:0]          tmo_next;
  logic [2:0]                avg_clamped;
  logic                      div_en;

  assign beat_ext    = ACC_W'(phase_err_beat);
  assign acc_next    = acc_q + beat_ext;
  assign cnt_next    = cnt_q + CNT_W'(1);
  assign cnt_target  = CNT_W'(1) << avg_l_q;
  assign tmo_next    = tmo_q + TMO_W'(1);
  assign avg_clamped = (cfg_avg_log2 > 3'(AVG_MAX)) ? 3'(AVG_MAX) : cfg_avg_log2;

  // The divider only runs while the measurement stays busy across the edge,
  // so it starts from zero on entry and never emits a tick after leaving.
  assign div_en = busy_q && busy_d;

  ddmtd_helper_div #(
    .DIV_W (DIV_W)
  ) u_helper_div (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .en      (div_en),
    .div     (div_l_q),
    .tick    (helper_tick)
  );

  always_comb begin
    state_d   = state_q;
    div_l_d   = div_l_q;
    avg_l_d   = avg_l_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    avg_d     = avg_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && ena) begin
          div_l_d = cfg_div;
          avg_l_d = avg_clamped;
          acc_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = DISCARD;
        end
      end
      DISCARD, ACCUM: begin
        // A result arriving together with the timeout-reaching tick wins.
        if (!ena) begin
          state_d = IDLE;
        end else if (phase_valid) begin
          tmo_d = '0;
          if (state_q == DISCARD) begin
            state_d = ACCUM;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_next;
            if (cnt_next == cnt_target) begin
              avg_d   = COUNT_W'(acc_next >>> avg_l_q);
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end else if (helper_tick) begin
          if (tmo_next == TMO_W'(TMO_TICKS)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            tmo_d = tmo_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_l_q   <= '0;
      avg_l_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      avg_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_l_q   <= div_l_d;
      avg_l_q   <= avg_l_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      avg_q     <= avg_d;
    end
  end

  assign busy        = busy_q;
  assign sampler_ena = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign avg_phase   = avg_q;

endmodule

// File: tb/tb_ddmtd_meas_ctrl.sv
// tb_ddmtd_meas_ctrl
//   Self-checking bench for ddmtd_meas_ctrl with TMO_TICKS=8. The expected
//   average is computed from the list of samples with integer floor division.
module tb_ddmtd_meas_ctrl;

  logic               clk_sys;
  logic               rst_n;
  logic               ena;
  logic               start;
  logic [7:0]         cfg_div;
  logic [2:0]         cfg_avg_log2;
  logic               phase_valid;
  logic signed [15:0] phase_err_beat;
  logic               helper_tick;
  logic               sampler_ena;
  logic               busy;
  logic               done;
  logic               timeout;
  logic signed [15:0] avg_phase;

  int total = 0;
  int bad   = 0;

  logic signed [15:0] model_avg;
  int                 samp_q[$];
  int                 discard_val;

  ddmtd_meas_ctrl #(
    .COUNT_W   (16),
    .DIV_W     (8),
    .AVG_MAX   (4),
    .TMO_TICKS (8)
  ) dut (
    .clk_sys        (clk_sys),
    .rst_n          (rst_n),
    .ena            (ena),
    .start          (start),
    .cfg_div        (cfg_div),
    .cfg_avg_log2   (cfg_avg_log2),
    .phase_valid    (phase_valid),
    .phase_err_beat (phase_err_beat),
    .helper_tick    (helper_tick),
    .sampler_ena    (sampler_ena),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .avg_phase      (avg_phase)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic tick_clk();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_start(input int div, input int avg);
    cfg_div      = 8'(div);
    cfg_avg_log2 = 3'(avg);
    ena          = 1'b1;
    start        = 1'b1;
    tick_clk();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || sampler_ena !== 1'b1) begin
      bad++;
      $display("[TB] FAIL start_busy: busy=%b sampler_ena=%b required 1/1", busy, sampler_ena);
    end
  endtask

  task automatic send_valid(input int v);
    phase_valid    = 1'b1;
    phase_err_beat = 16'(v);
    tick_clk();
    phase_valid    = 1'b0;
    phase_err_beat = 16'($urandom);
  endtask

  // Idle cycles between results; no pulse may appear while a measurement runs.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick_clk();
      total++;
      if (done !== 1'b0 || timeout !== 1'b0) begin
        bad++;
        $display("[TB] FAIL gap_pulse: done=%b timeout=%b required 0/0", done, timeout);
      end
    end
  endtask

  // Full measurement over samp_q; cfg inputs are scrambled after start.
  task automatic run_meas(input int div, input int cfg_avg, input bit poke_start);
    int n, d, sum, expv;
    logic signed [15:0] exp16;
    n   = (cfg_avg > 4) ? 4 : cfg_avg;
    d   = 1 << n;
    sum = 0;
    foreach (samp_q[i]) sum += samp_q[i];
    expv  = (sum >= 0) ? (sum / d) : -((-sum + d - 1) / d);
    exp16 = 16'(expv);
    do_start(div, cfg_avg);
    cfg_div      = 8'($urandom);
    cfg_avg_log2 = 3'($urandom);
    gap($urandom_range(0, 3));
    send_valid(discard_val);
    for (int i = 0; i < samp_q.size(); i++) begin
      if (poke_start && i == samp_q.size() / 2) begin
        start = 1'b1;
        gap(1);
        start = 1'b0;
      end
      gap($urandom_range(0, 3));
      send_valid(samp_q[i]);
      if (i != samp_q.size() - 1) begin
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL early_done: sample %0d done=%b busy=%b required 0/1", i, done, busy);
        end
      end
    end
    total++;
    if (done !== 1'b1 || timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL done_pulse: done=%b timeout=%b required 1/0", done, timeout);
    end
    total++;
    if (avg_phase !== exp16) begin
      bad++;
      $display("[TB] FAIL avg_value: avg_phase=%0d required %0d (n=%0d)", avg_phase, exp16, d);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_fall: busy=%b required 0", busy);
    end
    model_avg = exp16;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; cfg_div = '0; cfg_avg_log2 = '0;
    phase_valid = 1'b0; phase_err_beat = '0;
    model_avg = '0;
    #23;
    total++;
    if ({helper_tick, sampler_ena, busy, done, timeout} !== 5'b0 || avg_phase !== 16'sd0) begin
      bad++;
      $display("[TB] FAIL reset_state: outs=%b avg=%0d required 0", {helper_tick, sampler_ena, busy, done, timeout}, avg_phase);
    end
    tick_clk();
    rst_n = 1'b1;
    ena   = 1'b1;
    tick_clk();
  endtask

  task automatic test_divider();
    int div, per;
    for (int r = 0; r < 4; r++) begin
      div = (r == 0) ? 3 : $urandom_range(0, 5);
      per = div + 1;
      do_start(div, 4);
      for (int c = 1; c <= 3 * per; c++) begin
        tick_clk();
        total++;
        if (helper_tick !== ((c % per) == 0)) begin
          bad++;
          $display("[TB] FAIL tick_timing: div=%0d cycle %0d tick=%b required %b", div, c, helper_tick, (c % per) == 0);
        end
      end
      ena = 1'b0;
      tick_clk();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
        bad++;
        $display("[TB] FAIL abort_idle: busy=%b done=%b timeout=%b required 0", busy, done, timeout);
      end
      for (int c = 0; c < 6; c++) begin
        tick_clk();
        total++;
        if (helper_tick !== 1'b0) begin
          bad++;
          $display("[TB] FAIL idle_tick: tick=%b required 0", helper_tick);
        end
      end
      ena = 1'b1;
    end
  endtask

  task automatic test_fixed_avg();
    samp_q = '{10, 12, -2, 4};
    discard_val = 99;
    run_meas(1, 2, 1'b0);
    samp_q = '{-3, -4};
    discard_val = 1234;
    run_meas(0, 1, 1'b0);
  endtask

  task automatic test_idle_ignores();
    ena   = 1'b0;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL start_no_ena: busy=%b required 0", busy);
    end
    ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_valid($urandom_range(0, 500));
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || avg_phase !== model_avg) begin
        bad++;
        $display("[TB] FAIL idle_valid: busy=%b done=%b avg=%0d required 0/0/%0d", busy, done, avg_phase, model_avg);
      end
    end
  endtask

  // Counts helper ticks after the discard result; stops on the 8th.
  task automatic wait_8_ticks(output bit found);
    int ticks;
    ticks = 0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (helper_tick === 1'b1) ticks++;
      if (ticks == 8) begin
        found = 1'b1;
      end else begin
        if (timeout !== 1'b0) begin
          total++;
          bad++;
          $display("[TB] FAIL early_timeout: after %0d ticks timeout=%b required 0", ticks, timeout);
        end
        tick_clk();
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL tmo_bound: ticks=%0d required 8 within bound", ticks);
    end
  endtask

  task automatic test_timeout();
    bit found;
    do_start(1, 2);
    gap(2);
    send_valid(55);
    wait_8_ticks(found);
    tick_clk();
    total++;
    if (timeout !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_pulse: timeout=%b done=%b busy=%b required 1/0/0", timeout, done, busy);
    end
    total++;
    if (avg_phase !== model_avg) begin
      bad++;
      $display("[TB] FAIL timeout_avg: avg_phase=%0d required %0d", avg_phase, model_avg);
    end
    tick_clk();
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_width: timeout=%b required 0", timeout);
    end
    do_start(1, 2);
    gap(1);
    send_valid(-9);
    wait_8_ticks(found);
    send_valid(7);
    total++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL valid_wins: timeout=%b busy=%b required 0/1", timeout, busy);
    end
    ena = 1'b0;
    tick_clk();
    ena = 1'b1;
  endtask

  task automatic test_abort_restart();
    do_start(2, 2);
    gap(1);
    send_valid(300);
    send_valid(1000);
    start = 1'b1;
    gap(1);
    start = 1'b0;
    send_valid(2000);
    ena = 1'b0;
    tick_clk();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || avg_phase !== model_avg) begin
      bad++;
      $display("[TB] FAIL abort_mid: busy=%b done=%b avg=%0d required 0/0/%0d", busy, done, avg_phase, model_avg);
    end
    ena = 1'b1;
    gap(3);
    samp_q = '{-100, 40, 8, 20};
    discard_val = 5000;
    run_meas(2, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    int cfg;
    for (int r = 0; r < 6; r++) begin
      cfg = $urandom_range(0, 7);
      samp_q.delete();
      for (int i = 0; i < (1 << ((cfg > 4) ? 4 : cfg)); i++) begin
        logic signed [15:0] v;
        v = 16'($urandom);
        samp_q.push_back(int'(v));
      end
      discard_val = int'($urandom_range(0, 65535));
      run_meas($urandom_range(0, 3), cfg, r[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_start(2, 3);
    gap(1);
    send_valid(77);
    send_valid(-5);
    send_valid(12);
    #2;
    rst_n = 1'b0;
    #1;
    model_avg = '0;
    total++;
    if ({helper_tick, sampler_ena, busy, done, timeout} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_ctl: outs=%b required 0", {helper_tick, sampler_ena, busy, done, timeout});
    end
    total++;
    if (avg_phase !== model_avg) begin
      bad++;
      $display("[TB] FAIL reset_mid_avg: avg_phase=%0d required %0d", avg_phase, model_avg);
    end
    tick_clk();
    rst_n = 1'b1;
    tick_clk();
  endtask

  task automatic test_clamp();
    samp_q.delete();
    for (int i = 0; i < 16; i++) samp_q.push_back((i * 37) - 300);
    discard_val = -32000;
    run_meas(0, 7, 1'b0);
  endtask

  initial begin
    test_reset();
    test_divider();
    test_fixed_avg();
    test_idle_ignores();
    test_timeout();
    test_abort_restart();
    test_back_to_back();
    test_reset_mid();
    test_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
